// File: rtl/cmp_stim_gen.sv
// Operand-pair stimulus source and result checker for the 8-bit equality comparator.
// Optional feature macro: CMP_STIM_STOP_ON_ERR_EN (stop at first mismatch, report fail_idx).
module cmp_stim_gen #(
   parameter int unsigned NUM_VEC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  seed,
   input  logic        eq_in,
   output logic [7:0]  a_out,
   output logic [7:0]  b_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] err_cnt,
   output logic        pass
`ifdef CMP_STIM_STOP_ON_ERR_EN
   ,
   output logic [15:0] fail_idx
`endif
);

   localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [7:0]  r_lfsr;
   logic [15:0] r_idx;
   logic [15:0] r_err;
   logic        r_pass;
   logic [7:0]  r_a;
   logic [7:0]  r_b;

   logic [7:0]  w_seed_eff;
   logic [7:0]  w_lfsr_adv;
   logic [15:0] w_idx_inc;
   logic        w_exp;
   logic        w_mism;
   logic        w_last;
   logic        w_stop;
   logic [15:0] w_err_nxt;

   // Odd vectors flip exactly one bit, walking through bits 0..7 as idx advances.
   function automatic logic [7:0] f_mask(input logic [15:0] idx);
      f_mask = idx[0] ? (8'h01 << idx[3:1]) : 8'h00;
   endfunction

   assign w_seed_eff = (seed == 8'h00) ? 8'h01 : seed;
   assign w_lfsr_adv = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   assign w_idx_inc  = r_idx + 16'd1;
   assign w_exp      = ~r_idx[0];
   assign w_mism     = (eq_in != w_exp);
   assign w_last     = (r_idx == LAST_IDX);
   assign w_err_nxt  = (w_mism && (r_err != '1)) ? (r_err + 16'd1) : r_err;

`ifdef CMP_STIM_STOP_ON_ERR_EN
   assign w_stop = w_mism;
`else
   assign w_stop = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_DRIVE;
         S_DRIVE:  w_state_nxt = S_SAMPLE;
         S_SAMPLE: w_state_nxt = (w_last || w_stop) ? S_DONE : S_DRIVE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   // Operands are registered on the edge that enters DRIVE, so they are
   // computed from the next-cycle lfsr/idx rather than the current ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= '0;
         r_idx  <= '0;
         r_err  <= '0;
         r_pass <= 1'b0;
         r_a    <= '0;
         r_b    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_lfsr <= w_seed_eff;
                  r_idx  <= '0;
                  r_err  <= '0;
                  r_pass <= 1'b0;
                  r_a    <= w_seed_eff;
                  r_b    <= w_seed_eff;
               end
            end
            S_SAMPLE: begin
               r_err  <= w_err_nxt;
               r_idx  <= w_idx_inc;
               r_lfsr <= w_lfsr_adv;
               if (w_state_nxt == S_DRIVE) begin
                  r_a <= w_lfsr_adv;
                  r_b <= w_lfsr_adv ^ f_mask(w_idx_inc);
               end else begin
                  r_pass <= (w_err_nxt == '0);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CMP_STIM_STOP_ON_ERR_EN
   logic [15:0] r_fail_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fail_idx <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_fail_idx <= '0;
      end else if ((r_state == S_SAMPLE) && w_mism && (r_err == '0)) begin
         r_fail_idx <= r_idx;
      end
   end

   assign fail_idx = r_fail_idx;
`endif

   assign a_out   = r_a;
   assign b_out   = r_b;
   assign err_cnt = r_err;
   assign pass    = r_pass;

endmodule

// File: doc/cmp_stim_gen.md
# cmp_stim_gen

Self-checking operand source for the 8-bit equality comparator. On `start` it drives a sequence of LFSR-derived operand pairs on `a_out`/`b_out`, alternating equal and single-bit-different pairs. It samples the comparator's `eq_in` result for each pair and checks it against the expected value. It counts mismatches and reports pass/fail, and serves as the initiator end of the comparator interface in bring-up and BIST builds.

## Interface
- `NUM_VEC`, 16, number of operand pairs per run; legal range 2..65535.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle run request; ignored unless idle.
- `seed`  in  8  LFSR seed, captured on an accepted `start`.
- `eq_in`  in  1  comparator result for the current pair.
- `a_out`  out  8  operand A to the comparator.
- `b_out`  out  8  operand B to the comparator.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse at run end.
- `err_cnt`  out  16  mismatch count, saturating at 16'hFFFF.
- `pass`  out  1  `err_cnt == 0`; valid from `done` until the next accepted `start`.
- `fail_idx`  out  16  index of the first mismatching vector; present only with the macro.

## Operation
- States and transitions:
  - IDLE: `start` -> DRIVE.
  - DRIVE: always -> SAMPLE.
  - SAMPLE: if `idx == NUM_VEC-1` -> DONE, else -> DRIVE.
  - DONE: always -> IDLE.
- Accepted `start` in IDLE:
  - `lfsr` <= `seed`, or 8'h01 if `seed == 0`.
  - `idx` <= 0; `err_cnt` <= 0; `pass` <= 0.
- On entering DRIVE for vector `idx`:
  - `a_out` <= `lfsr`.
  - `b_out` <= `lfsr ^ mask`.
  - `mask` = 0 when `idx[0]==0`; otherwise 8'h01 << `idx[3:1]`.
  - Expected result `exp` = `~idx[0]`.
- SAMPLE:
  - `eq_in` is sampled at the clock edge that ends SAMPLE.
  - If `eq_in != exp`, `err_cnt` increments, saturating.
  - `idx` then increments.
  - `lfsr` advances: `{lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}` (x^8+x^6+x^5+x^4+1).
- DONE:
  - `done` = 1 for this cycle only.
  - `pass` <= (`err_cnt == 0`), accounting for the final vector's sample.
- `a_out`/`b_out` hold their values through DRIVE and SAMPLE and keep the last pair in IDLE.
- `start` in any state other than IDLE is ignored with no side effect. That includes `start` in the DONE cycle.

## Timing
- Reset (async, immediate):
  - State = IDLE.
  - `a_out` = `b_out` = 0; `busy` = `done` = `pass` = 0; `err_cnt` = 0; `fail_idx` = 0.
- Reset asserted mid-run aborts the run. There is no `done` pulse, and the block restarts only on a new `start`.
- Each vector takes 2 cycles: operands are stable one full cycle before `eq_in` is sampled. This tolerates a comparator with 0 or 1 cycle of registered latency.
- With the accepted `start` sampled at edge 0:
  - Vector k is driven in cycle 2k+1 and sampled at the end of cycle 2k+2.
  - `done` is high in cycle 2·NUM_VEC+1.
  - `busy` is high in cycles 1..2·NUM_VEC+1.
- A new `start` is accepted no earlier than cycle 2·NUM_VEC+2.

## Configuration
- `CMP_STIM_STOP_ON_ERR_EN` defined:
  - On the first mismatch, `fail_idx` <= `idx`.
  - State goes SAMPLE -> DONE immediately, with `err_cnt` = 1 and `pass` = 0.
  - `fail_idx` resets to 0 on `start` and holds until the next `start`.
- Not defined:
  - The `fail_idx` port and its logic are absent.
  - All `NUM_VEC` vectors always run.

## Test plan
- Reset: assert `rst` asynchronously mid-run (cycle 5, NUM_VEC=4) -> all outputs return to reset values without a clock edge. No `done` follows until a new `start`.
- NUM_VEC=4, `seed`=8'h01, ideal comparator on `eq_in`:
  - Pairs are (01,01), (02,03), (04,04), (08,0A) in cycles 1, 3, 5, 7.
  - `done` is high in cycle 9 only; `err_cnt`=0, `pass`=1.
- Same as above with `seed`=8'h00 -> identical pair sequence and result (zero seed maps to 01).
- NUM_VEC=4, `eq_in` tied 1 -> `err_cnt`=2, `pass`=0, `done` in cycle 9.
- `start` pulsed in cycles 3 and 9 of a NUM_VEC=4 run -> both ignored. `busy` drops in cycle 10; `start` in cycle 10 is accepted.
- With `CMP_STIM_STOP_ON_ERR_EN`, `eq_in` tied 0 -> mismatch on vector 0. `done` in cycle 3, `fail_idx`=0, `err_cnt`=1, `pass`=0.
